spu_op_scheduler: RTL and testbench
===================================

SPU_OP_SCHEDULER -- requirements
Module: spu_op_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max cycles waited for dp_done before abort.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ena  in  1  design selected; low freezes all state, outputs held.
REQ-005 cmd_valid  in  1  host byte valid.
REQ-006 cmd_byte  in  8  host command/operand byte.
REQ-007 cmd_ready  out  1  scheduler can accept byte.
REQ-008 dp_start  out  1  one-cycle pulse launching datapath op.
REQ-009 dp_op  out  3  opcode to datapath, stable from dp_start to dp_done.
REQ-010 dp_a, dp_b  out  8 each  operands, stable from dp_start to dp_done.
REQ-011 dp_done  in  1  datapath completion pulse.
REQ-012 dp_result  in  8  result, valid with dp_done.
REQ-013 res_valid  out  1  result byte available.
REQ-014 res_byte  out  8  result byte.
REQ-015 res_ready  in  1  host consumes result.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 err_code  out  2  0 none, 1 bad opcode, 2 timeout.

Function
REQ-018 Frame = 3 bytes: header {op[2:0], 5'b0}, A, B; byte accepted when cmd_valid & cmd_ready & ena.
REQ-019 FSM states: IDLE, GET_A, GET_B, ISSUE, WAIT, OUT.
REQ-020 cmd_ready high only in IDLE, GET_A, GET_B.
REQ-021 IDLE: valid header (op 0..5, low 5 bits zero) -> GET_A, err_code cleared to 0.
REQ-022 IDLE: op 6/7 or nonzero low bits -> stay IDLE, err_code=1, frame header dropped.
REQ-023 GET_A accept -> latch dp_a, GET_B; GET_B accept -> latch dp_b, ISSUE.
REQ-024 ISSUE: dp_start=1 for exactly one cycle, -> WAIT next cycle; header-to-dp_start latency 1 cycle after B accepted.
REQ-025 WAIT: dp_done -> latch dp_result into res_byte, -> OUT; dp_done outside WAIT ignored.
REQ-026 WAIT: watchdog counts cycles from WAIT entry; reaching TIMEOUT_CYC without dp_done -> err_code=2, IDLE, no result.
REQ-027 dp_done on same cycle watchdog expires: dp_done wins, result delivered.
REQ-028 OUT: res_valid=1, res_byte stable until res_valid & res_ready; then -> IDLE same edge.
REQ-029 OUT with res_ready already high on entry: result consumed in one cycle.
REQ-030 ena low: no transitions, watchdog halted, dp_start suppressed and reissued when ena returns if still in ISSUE.
REQ-031 err_code sticky until next valid header.

Reset
REQ-032 rst_n low: state IDLE, cmd_ready=0 during reset, 1 after; dp_start=0, dp_op/dp_a/dp_b=0, res_valid=0, res_byte=0, busy=0, err_code=0, watchdog=0.
REQ-033 Reset mid-frame or mid-WAIT discards frame; late dp_done after reset ignored.

Structure
REQ-034 Package spu_pkg: opcode enum (6 valid codes), FSM state enum, err_code constants, default TIMEOUT_CYC.
REQ-035 Sub-module spu_watchdog: 8-bit counter with clear, enable, expire output.

Verification
REQ-036 Frame 0x20,0x12,0x34; dp_done+0x46 two cycles after start -> dp_op=1, dp_a=0x12, dp_b=0x34, res_byte=0x46, busy low after res_ready.
REQ-037 Header 0xE0 -> err_code=1, cmd_ready stays high, next valid frame clears err_code and completes.
REQ-038 Valid frame, dp_done never asserted -> err_code=2 exactly TIMEOUT_CYC cycles after WAIT entry, res_valid never high.
REQ-039 res_ready low 5 cycles in OUT -> res_valid/res_byte held, cmd_ready low throughout.
REQ-040 rst_n pulsed in WAIT, then dp_done -> outputs at reset values, no res_valid.
REQ-041 ena dropped during GET_B and ISSUE -> no byte accepted, single dp_start after ena restored.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU op scheduler: opcodes, FSM states,
// error codes and the default watchdog limit.
package spu_pkg;

    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5
    } spu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_A = 3'd1,
        ST_GET_B = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_OUT   = 3'd5
    } spu_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_OP  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // A header names one of the six opcodes and keeps its low five bits clear.
    function automatic logic header_ok(input logic [7:0] hdr);
        return (hdr[7:5] <= OP_XOR) && (hdr[4:0] == 5'd0);
    endfunction

endpackage

// File: rtl/spu_watchdog.sv
// Cycle counter that flags expiry on the LIMIT-th enabled cycle after a clear.
module spu_watchdog
    import spu_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt_q, cnt_d;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is flagged during the cycle whose clock edge would complete LIMIT cycles.
    assign expire = en && !clr && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/spu_op_scheduler.sv
// SPU op scheduler: collects 3-byte host frames, issues one datapath op and
// hands the result back; a watchdog aborts a datapath that never completes.
module spu_op_scheduler
    import spu_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    output logic       dp_start,
    output logic [2:0] dp_op,
    output logic [7:0] dp_a,
    output logic [7:0] dp_b,
    input  logic       dp_done,
    input  logic [7:0] dp_result,
    output logic       res_valid,
    output logic [7:0] res_byte,
    input  logic       res_ready,
    output logic       busy,
    output logic [1:0] err_code
);

    spu_state_e state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] res_q, res_d;
    logic [1:0] err_q, err_d;
    logic       cmd_fire;
    logic       hdr_ok;
    logic       wd_clr;
    logic       wd_en;
    logic       wd_expire;

    assign cmd_fire = cmd_valid && cmd_ready && ena;
    assign hdr_ok   = header_ok(cmd_byte);
    assign wd_clr   = (state_q != ST_WAIT);
    assign wd_en    = ena && (state_q == ST_WAIT);

    spu_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // With ena low the state is frozen, so nothing below advances.
    always_comb begin
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                ST_IDLE:  if (cmd_fire && hdr_ok) state_d = ST_GET_A;
                ST_GET_A: if (cmd_fire) state_d = ST_GET_B;
                ST_GET_B: if (cmd_fire) state_d = ST_ISSUE;
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (dp_done) begin
                        state_d = ST_OUT;
                    end else if (wd_expire) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_OUT:   if (res_ready) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // cmd_ready is held low while reset is asserted even though the state reads IDLE.
    always_comb begin
        cmd_ready = 1'b0;
        dp_start  = 1'b0;
        res_valid = 1'b0;
        busy      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE, ST_GET_A, ST_GET_B: cmd_ready = rst_n;
            ST_ISSUE:                    dp_start  = ena;
            ST_OUT:                      res_valid = 1'b1;
            default:                     ;
        endcase
    end

    always_comb begin
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        err_d = err_q;
        if (ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (hdr_ok) begin
                            op_d  = cmd_byte[7:5];
                            err_d = ERR_NONE;
                        end else begin
                            err_d = ERR_BAD_OP;
                        end
                    end
                end
                ST_GET_A: if (cmd_fire) a_d = cmd_byte;
                ST_GET_B: if (cmd_fire) b_d = cmd_byte;
                ST_WAIT: begin
                    if (dp_done) begin
                        res_d = dp_result;
                    end else if (wd_expire) begin
                        err_d = ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            err_q <= ERR_NONE;
        end else begin
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    assign dp_op    = op_q;
    assign dp_a     = a_q;
    assign dp_b     = b_q;
    assign res_byte = res_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_spu_op_scheduler.sv
// Self-checking bench for spu_op_scheduler: issue and result scoreboards fed
// by the stimulus tasks and drained by a negedge monitor.
module tb_spu_op_scheduler;
    import spu_pkg::*;

    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       dp_done = 1'b0;
    logic [7:0] dp_result = 8'h00;
    logic       res_ready = 1'b0;

    logic       cmd_ready;
    logic       dp_start;
    logic [2:0] dp_op;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic       res_valid;
    logic [7:0] res_byte;
    logic       busy;
    logic [1:0] err_code;

    spu_op_scheduler #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .cmd_ready (cmd_ready),
        .dp_start  (dp_start),
        .dp_op     (dp_op),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_done   (dp_done),
        .dp_result (dp_result),
        .res_valid (res_valid),
        .res_byte  (res_byte),
        .res_ready (res_ready),
        .busy      (busy),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } issue_t;

    issue_t     exp_issue[$];
    logic [7:0] exp_res[$];
    issue_t     mon_e;
    int         start_cnt = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Monitor: every dp_start and every result handshake is matched against the scoreboards.
    always @(negedge clk) begin
        if (dp_start) begin
            start_cnt++;
            if (exp_issue.size() == 0) begin
                check("spurious_dp_start", 1, 0);
            end else begin
                mon_e = exp_issue.pop_front();
                check("dp_op", dp_op, mon_e.op);
                check("dp_a", dp_a, mon_e.a);
                check("dp_b", dp_b, mon_e.b);
            end
        end
        if (rst_n && ena && res_valid && res_ready) begin
            if (exp_res.size() == 0) check("spurious_result", 1, 0);
            else check("res_byte", res_byte, exp_res.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 0, 1);
        cmd_valid = 1'b1;
        cmd_byte  = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_frame(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input int delay, input int hold, input bit rr_early);
        logic [7:0] r;
        r = alu(op, a, b);
        exp_issue.push_back(issue_t'({op, a, b}));
        exp_res.push_back(r);
        send_byte({op, 5'd0});
        check("err_cleared_by_header", err_code, ERR_NONE);
        send_byte(a);
        send_byte(b);
        check("dp_start_latency", dp_start, 1);
        check("busy_in_issue", busy, 1);
        if (rr_early) res_ready = 1'b1;
        tick();
        repeat (delay - 1) tick();
        dp_done   = 1'b1;
        dp_result = r;
        tick();
        dp_done   = 1'b0;
        dp_result = 8'h00;
        check("res_valid_out", res_valid, 1);
        check("res_byte_out", res_byte, r);
        check("cmd_ready_out", cmd_ready, 0);
        check("dp_a_held", dp_a, a);
        if (rr_early) begin
            tick();
            res_ready = 1'b0;
        end else begin
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_res_valid", res_valid, 1);
                check("hold_res_byte", res_byte, r);
                check("hold_cmd_ready", cmd_ready, 0);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        check("busy_after_result", busy, 0);
        check("res_valid_after_result", res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        bit res_seen;

        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_dp_start", dp_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_err", err_code, ERR_NONE);
        check("rst_dp_op", dp_op, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("ready_after_rst", cmd_ready, 1);

        // Reference frame: ADD 0x12 + 0x34, done two cycles after start.
        do_frame(3'd1, 8'h12, 8'h34, 2, 0, 1'b0);

        // Bad headers: unknown opcode, then nonzero low bits.
        s0 = start_cnt;
        send_byte(8'hE0);
        check("bad_op_err", err_code, ERR_BAD_OP);
        check("bad_op_ready", cmd_ready, 1);
        check("bad_op_busy", busy, 0);
        send_byte(8'h21);
        check("bad_low_err", err_code, ERR_BAD_OP);
        check("bad_low_busy", busy, 0);
        repeat (3) tick();
        check("bad_err_sticky", err_code, ERR_BAD_OP);
        check("bad_no_start", start_cnt, s0);
        do_frame(3'd2, 8'h50, 8'h20, 3, 0, 1'b0);

        do_frame(3'd3, 8'hCC, 8'hAA, 1, 5, 1'b0);
        do_frame(3'd4, 8'h3C, 8'h0F, 4, 0, 1'b1);
        do_frame(3'd0, 8'h5A, 8'hFF, 2, 1, 1'b0);

        // Timeout: dp_done never arrives.
        exp_issue.push_back(issue_t'({3'd5, 8'h11, 8'h22}));
        send_byte(8'hA0);
        send_byte(8'h11);
        send_byte(8'h22);
        check("to_start", dp_start, 1);
        tick();
        res_seen = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            if (res_valid) res_seen = 1'b1;
        end
        check("to_err_before", err_code, ERR_NONE);
        check("to_busy_before", busy, 1);
        tick();
        check("to_err", err_code, ERR_TIMEOUT);
        check("to_busy", busy, 0);
        check("to_res_valid", res_valid, 0);
        check("to_no_res_seen", res_seen, 0);
        repeat (4) tick();
        check("to_err_sticky", err_code, ERR_TIMEOUT);

        // dp_done on the expiry cycle wins.
        exp_issue.push_back(issue_t'({3'd1, 8'h01, 8'h02}));
        exp_res.push_back(8'h03);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h02);
        check("race_start", dp_start, 1);
        tick();
        repeat (TO - 1) tick();
        dp_done   = 1'b1;
        dp_result = 8'h03;
        tick();
        dp_done   = 1'b0;
        check("race_res_valid", res_valid, 1);
        check("race_err", err_code, ERR_NONE);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("race_busy", busy, 0);

        // ena low in GET_B and in ISSUE.
        exp_issue.push_back(issue_t'({3'd5, 8'h0F, 8'hF0}));
        exp_res.push_back(8'hFF);
        send_byte(8'hA0);
        send_byte(8'h0F);
        s0 = start_cnt;
        ena = 1'b0;
        cmd_valid = 1'b1;
        cmd_byte = 8'hF0;
        repeat (3) tick();
        check("ena_getb_ready", cmd_ready, 1);
        check("ena_getb_busy", busy, 1);
        ena = 1'b1;
        tick();
        cmd_valid = 1'b0;
        ena = 1'b0;
        #1;
        check("ena_issue_no_start", dp_start, 0);
        repeat (3) tick();
        check("ena_issue_cnt", start_cnt, s0);
        check("ena_issue_busy", busy, 1);
        ena = 1'b1;
        #1;
        check("ena_restart", dp_start, 1);
        tick();
        check("ena_single_start", start_cnt, s0 + 1);
        check("ena_wait_no_start", dp_start, 0);
        dp_done   = 1'b1;
        dp_result = 8'hFF;
        tick();
        dp_done   = 1'b0;
        check("ena_res_valid", res_valid, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("ena_busy_done", busy, 0);

        // Reset pulsed mid-WAIT, then a late dp_done.
        exp_issue.push_back(issue_t'({3'd2, 8'h77, 8'h07}));
        send_byte(8'h40);
        send_byte(8'h77);
        send_byte(8'h07);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dp_op", dp_op, 0);
        check("mid_rst_dp_a", dp_a, 0);
        check("mid_rst_dp_b", dp_b, 0);
        check("mid_rst_res_byte", res_byte, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_err", err_code, ERR_NONE);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", cmd_ready, 1);
        dp_done   = 1'b1;
        dp_result = 8'hAA;
        tick();
        dp_done   = 1'b0;
        check("late_done_res_valid", res_valid, 0);
        check("late_done_busy", busy, 0);
        check("late_done_res_byte", res_byte, 0);

        do_frame(3'd2, 8'h10, 8'h30, 2, 0, 1'b0);

        check("issue_queue_empty", exp_issue.size(), 0);
        check("result_queue_empty", exp_res.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
